ddr3_rd_fill_seq: RTL and testbench
===================================

Name: ddr3_rd_fill_seq

Overview:
- Upstream sequencer for the DDR3 read controller.
- Pops one fill descriptor at a time from the fill-header FIFO (first-word-fall-through) and presents its start address and burst count.
- Runs a four-phase enable_reading / reading_done handshake with the read controller, then holds the enable low long enough for the controller's input synchroniser to return it to idle.
- Keeps fill and skip statistics for readout.

Parameters:
- DONE_SYNC_STAGES, 2, flops in the reading_done synchroniser (legal range 2..4).
- MIN_LOW_CYCLES, 6, minimum clk cycles enable_reading stays low between fills (legal range 4..255).
- TIMEOUT_CYCLES, 24'hFFFFFF, watchdog limit in REQ; used only with the optional feature.

Ports:
- clk  in  1  sequencer clock.
- reset  in  1  synchronous, active-high.
- acq_enabled  in  1  acquisition active; no new fill starts while high.
- hdr_fifo_empty  in  1  fill-header FIFO empty.
- hdr_fifo_dout  in  47  descriptor: [46:24] start burst address, [23:0] burst count.
- hdr_fifo_rd_en  out  1  one-cycle pop strobe.
- ddr3_rd_start_addr  out  23  latched start burst address.
- ddr3_rd_burst_cnt  out  24  latched burst count.
- enable_reading  out  1  level request to the read controller.
- reading_done  in  1  completion level from the DDR3 domain; asynchronous to clk.
- fill_busy  out  1  high in every state except IDLE.
- fills_done  out  32  completed fills; wraps.
- fills_skipped  out  16  zero-length descriptors; saturating.
- rd_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Low-hold counter 0.
- reading_done passes through DONE_SYNC_STAGES flops; the result is done_s.
- All outputs are registered.
- State machine: IDLE, LOAD, REQ, RELEASE.
- IDLE:
  - If !hdr_fifo_empty && !acq_enabled: pulse hdr_fifo_rd_en for exactly one cycle.
  - On the same edge, latch hdr_fifo_dout[46:24] into ddr3_rd_start_addr and hdr_fifo_dout[23:0] into ddr3_rd_burst_cnt.
  - Go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - If the latched count is 0: increment fills_skipped, saturating at 16'hFFFF; go to IDLE. enable_reading is never raised for this descriptor.
  - Otherwise set enable_reading to 1 and go to REQ.
  - Latency from the pop strobe to enable_reading high: 2 cycles.
- REQ:
  - enable_reading held at 1.
  - ddr3_rd_start_addr and ddr3_rd_burst_cnt are stable for the whole time enable_reading is high.
  - On done_s=1: clear enable_reading, increment fills_done (mod 2^32), load the low-hold counter with MIN_LOW_CYCLES, go to RELEASE.
- RELEASE:
  - enable_reading held at 0; the low-hold counter decrements to 0.
  - Exit to IDLE only when done_s=0 AND the counter is 0.
  - A descriptor arriving in the FIFO during RELEASE is not popped until IDLE.
- acq_enabled:
  - Gates only the IDLE→LOAD transition.
  - Rising during REQ or RELEASE has no effect here; the read controller gates its own address issue.
- hdr_fifo_empty asserted in IDLE: no pop; fill_busy stays 0.
- done_s already high on entry to REQ (stale completion from a previous fill): cannot happen, because RELEASE waits for done_s=0. No special handling.
- reset mid-fill:
  - Immediate return to IDLE with enable_reading=0, which also returns the read controller to idle.
  - Counters and rd_timeout clear.
  - A descriptor already popped is lost.
- The address and count registers keep their last values in IDLE.

Optional Feature:
- Macro: DDR3_RD_FILL_TIMEOUT_EN.
- Defined:
  - A 24-bit watchdog clears on REQ entry and increments each REQ cycle.
  - When it reaches TIMEOUT_CYCLES: set rd_timeout (sticky until reset), clear enable_reading, go to RELEASE, and do NOT increment fills_done.
  - If done_s rises on the same cycle the watchdog expires, done_s wins: count the fill normally and leave rd_timeout unchanged.
- Not defined:
  - No watchdog logic.
  - rd_timeout tied to 0.
  - REQ waits indefinitely for done_s.

Decomposition:
- Package ddr3_rd_pkg holds:
  - the state encoding;
  - header field constants: HDR_ADDR_MSB=46, HDR_ADDR_LSB=24, HDR_CNT_MSB=23;
  - widths ADDR_W=23 and CNT_W=24.
- One sub-module: ddr3_sync_bit, a parameterised multi-flop level synchroniser used for reading_done.

Test Plan:
- Single fill:
  - Stimulus: descriptor addr=23'h000100, cnt=24'd16; model raises reading_done 40 cycles after enable_reading.
  - Required: one rd_en pulse; enable_reading high 2 cycles after the pulse; ddr3_rd_start_addr=23'h000100 and ddr3_rd_burst_cnt=24'd16 stable throughout; fills_done=1; enable_reading low for at least MIN_LOW_CYCLES.
- Zero length:
  - Stimulus: descriptor cnt=0, followed by a descriptor with cnt=4.
  - Required: fills_skipped=1; enable_reading is never raised for the first descriptor; the second completes and fills_done=1.
- Back-to-back:
  - Stimulus: 3 queued descriptors; model holds reading_done high for 10 cycles after enable_reading drops.
  - Required: the next pop happens only after done_s=0 and the hold counter expires; fills_done=3.
- acq_enabled:
  - Stimulus: acq_enabled high with a non-empty FIFO for 100 cycles.
  - Required: no pop during those cycles; first pop 1 cycle after acq_enabled falls.
- Reset mid-REQ:
  - Stimulus: reset pulsed while enable_reading=1.
  - Required: next cycle enable_reading=0, state IDLE, fills_done=0.
- Timeout (macro defined, TIMEOUT_CYCLES=100):
  - Stimulus: reading_done never asserted.
  - Required: enable_reading falls after 100 cycles in REQ; rd_timeout=1 and stays sticky; fills_done=0.

Source files
------------

// File: rtl/ddr3_rd_pkg.sv
// Shared types and descriptor field layout for the DDR3 read fill sequencer.
package ddr3_rd_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned CNT_W  = 24;

  localparam int unsigned HDR_ADDR_MSB = 46;
  localparam int unsigned HDR_ADDR_LSB = 24;
  localparam int unsigned HDR_CNT_MSB  = 23;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReq,
    StRelease
  } fill_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/ddr3_sync_bit.sv
// Multi-flop level synchroniser for a single asynchronous control bit.
module ddr3_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ddr3_rd_fill_seq.sv
// Pops fill descriptors and runs the enable_reading/reading_done handshake with the read
// controller. Optional REQ watchdog enabled by defining DDR3_RD_FILL_TIMEOUT_EN.
module ddr3_rd_fill_seq
  import ddr3_rd_pkg::*;
#(
  parameter int unsigned DONE_SYNC_STAGES = 2,
  parameter int unsigned MIN_LOW_CYCLES   = 6,
  parameter int unsigned TIMEOUT_CYCLES   = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acq_enabled,
  input  logic              hdr_fifo_empty,
  input  logic [46:0]       hdr_fifo_dout,
  output logic              hdr_fifo_rd_en,
  output logic [ADDR_W-1:0] ddr3_rd_start_addr,
  output logic [CNT_W-1:0]  ddr3_rd_burst_cnt,
  output logic              enable_reading,
  input  logic              reading_done,
  output logic              fill_busy,
  output logic [31:0]       fills_done,
  output logic [15:0]       fills_skipped,
  output logic              rd_timeout
);

  localparam logic [7:0] HoldInit = 8'(MIN_LOW_CYCLES);

  logic done_s;

  ddr3_sync_bit #(
    .STAGES (DONE_SYNC_STAGES)
  ) u_done_sync (
    .clk   (clk),
    .reset (reset),
    .d     (reading_done),
    .q     (done_s)
  );

  fill_state_e       state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic [31:0]       done_cnt_q, done_cnt_d;
  logic [15:0]       skip_cnt_q, skip_cnt_d;
  logic [7:0]        hold_q, hold_d;

`ifdef DDR3_RD_FILL_TIMEOUT_EN
  localparam logic [23:0] WdLast = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] wd_q, wd_d;
  logic        to_q, to_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    done_cnt_d = done_cnt_q;
    skip_cnt_d = skip_cnt_q;
    hold_d     = hold_q;
`ifdef DDR3_RD_FILL_TIMEOUT_EN
    wd_d       = wd_q;
    to_d       = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        // FWFT: the descriptor is valid on dout, so latch it on the pop edge.
        if (!hdr_fifo_empty && !acq_enabled) begin
          rd_en_d = 1'b1;
          addr_d  = hdr_fifo_dout[HDR_ADDR_MSB:HDR_ADDR_LSB];
          cnt_d   = hdr_fifo_dout[HDR_CNT_MSB:0];
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (cnt_q == '0) begin
          skip_cnt_d = sat_inc16(skip_cnt_q);
          state_d    = StIdle;
        end else begin
          state_d = StReq;
`ifdef DDR3_RD_FILL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      StReq: begin
        // Request rises on the first REQ edge: two cycles after the pop strobe.
        en_d = 1'b1;
        if (done_s) begin
          en_d       = 1'b0;
          done_cnt_d = done_cnt_q + 32'd1;
          hold_d     = HoldInit;
          state_d    = StRelease;
        end
`ifdef DDR3_RD_FILL_TIMEOUT_EN
        else if (wd_q == WdLast) begin
          en_d    = 1'b0;
          to_d    = 1'b1;
          hold_d  = HoldInit;
          state_d = StRelease;
        end else begin
          wd_d = wd_q + 24'd1;
        end
`endif
      end
      StRelease: begin
        en_d = 1'b0;
        if (hold_q != '0) begin
          hold_d = hold_q - 8'd1;
        end else if (!done_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_cnt_q <= '0;
      skip_cnt_q <= '0;
      hold_q     <= '0;
`ifdef DDR3_RD_FILL_TIMEOUT_EN
      wd_q       <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_cnt_q <= done_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      hold_q     <= hold_d;
`ifdef DDR3_RD_FILL_TIMEOUT_EN
      wd_q       <= wd_d;
      to_q       <= to_d;
`endif
    end
  end

  assign hdr_fifo_rd_en     = rd_en_q;
  assign ddr3_rd_start_addr = addr_q;
  assign ddr3_rd_burst_cnt  = cnt_q;
  assign enable_reading     = en_q;
  assign fill_busy          = busy_q;
  assign fills_done         = done_cnt_q;
  assign fills_skipped      = skip_cnt_q;
`ifdef DDR3_RD_FILL_TIMEOUT_EN
  assign rd_timeout         = to_q;
`else
  assign rd_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_rd_fill_seq.sv
// Randomised bench: FWFT FIFO model, read-controller model and a rule-level scoreboard.
module tb_ddr3_rd_fill_seq;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned MIN_LOW = 6;
  localparam int unsigned TO_CYC  = 100;

  logic        clk;
  logic        reset;
  logic        acq_enabled;
  logic        hdr_fifo_empty;
  logic [46:0] hdr_fifo_dout;
  logic        hdr_fifo_rd_en;
  logic [22:0] ddr3_rd_start_addr;
  logic [23:0] ddr3_rd_burst_cnt;
  logic        enable_reading;
  logic        reading_done;
  logic        fill_busy;
  logic [31:0] fills_done;
  logic [15:0] fills_skipped;
  logic        rd_timeout;

  ddr3_rd_fill_seq #(
    .DONE_SYNC_STAGES (SYNC),
    .MIN_LOW_CYCLES   (MIN_LOW),
    .TIMEOUT_CYCLES   (TO_CYC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .acq_enabled        (acq_enabled),
    .hdr_fifo_empty     (hdr_fifo_empty),
    .hdr_fifo_dout      (hdr_fifo_dout),
    .hdr_fifo_rd_en     (hdr_fifo_rd_en),
    .ddr3_rd_start_addr (ddr3_rd_start_addr),
    .ddr3_rd_burst_cnt  (ddr3_rd_burst_cnt),
    .enable_reading     (enable_reading),
    .reading_done       (reading_done),
    .fill_busy          (fill_busy),
    .fills_done         (fills_done),
    .fills_skipped      (fills_skipped),
    .rd_timeout         (rd_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [46:0] fifo_q[$];
  logic [46:0] cur_desc;
  int          cyc = 0;
  int          pop_cyc = -100;
  int          last_fall_cyc = -1;
  int          done_fall_cyc = -1;
  int          en_cycles = 0;
  int          en_len = 0;
  int          low_cycles = 0;
  int          resp_delay = 40;
  int          hold_cycles = 0;
  int          pop_count = 0;
  bit          rand_mode = 0;
  bit          skip_pending = 0;
  bit          done_raised = 0;
  logic        prev_en = 0;
  logic        prev_rd_en = 0;
  logic [31:0] exp_done = 0;
  logic [15:0] exp_skip = 0;
  logic        exp_timeout = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fifo_refresh();
    hdr_fifo_empty = (fifo_q.size() == 0);
    hdr_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 47'd0;
  endtask

  task automatic push(input logic [22:0] addr, input logic [23:0] cnt);
    fifo_q.push_back({addr, cnt});
    fifo_refresh();
  endtask

  // One clock: observe at the falling edge, update the models, check the rules.
  task automatic step();
    logic acq_at, empty_at, reset_at;
    acq_at   = acq_enabled;
    empty_at = hdr_fifo_empty;
    reset_at = reset;
    @(negedge clk);
    cyc++;
    if (reset_at) begin
      check("rst_en", enable_reading, 0);
      check("rst_rd_en", hdr_fifo_rd_en, 0);
      check("rst_busy", fill_busy, 0);
      check("rst_fills_done", fills_done, 0);
      check("rst_fills_skipped", fills_skipped, 0);
      check("rst_timeout", rd_timeout, 0);
      check("rst_addr", ddr3_rd_start_addr, 0);
      check("rst_cnt", ddr3_rd_burst_cnt, 0);
      exp_done = 0; exp_skip = 0; exp_timeout = 0; skip_pending = 0;
      prev_en = 0; prev_rd_en = 0; reading_done = 0; done_raised = 0;
      last_fall_cyc = -1; done_fall_cyc = -1; en_cycles = 0; low_cycles = 0;
      return;
    end
    if (skip_pending) begin
      if (exp_skip != 16'hFFFF) exp_skip++;
      skip_pending = 0;
    end
    if (hdr_fifo_rd_en) begin
      pop_count++;
      check("pop_one_cycle", prev_rd_en, 0);
      check("pop_gate", {acq_at, empty_at}, 2'b00);
      check("pop_done_low", reading_done, 0);
      if (last_fall_cyc >= 0) check("pop_after_hold", (cyc - last_fall_cyc) >= MIN_LOW + 1, 1);
      if (done_fall_cyc >= 0) check("pop_after_sync", (cyc - done_fall_cyc) >= SYNC + 1, 1);
      check("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) begin
        cur_desc = fifo_q.pop_front();
        fifo_refresh();
        pop_cyc = cyc;
        check("latch_addr", ddr3_rd_start_addr, cur_desc[46:24]);
        check("latch_cnt", ddr3_rd_burst_cnt, cur_desc[23:0]);
        if (cur_desc[23:0] == 24'd0) skip_pending = 1;
      end
    end
    if (enable_reading && !prev_en) begin
      check("en_latency", cyc - pop_cyc, 2);
      check("en_nonzero_cnt", cur_desc[23:0] != 24'd0, 1);
      if (last_fall_cyc >= 0) check("en_low_min", (cyc - last_fall_cyc) >= MIN_LOW, 1);
      en_cycles = 0;
      done_raised = 0;
      if (rand_mode) begin
        resp_delay  = $urandom_range(1, 40);
        hold_cycles = $urandom_range(0, 10);
      end
    end
    if (enable_reading) begin
      check("stable_addr", ddr3_rd_start_addr, cur_desc[46:24]);
      check("stable_cnt", ddr3_rd_burst_cnt, cur_desc[23:0]);
      en_cycles++;
      if (en_cycles == resp_delay) begin
        reading_done = 1;
        done_raised  = 1;
      end
    end
    if (!enable_reading && prev_en) begin
      if (done_raised) exp_done++;
      else exp_timeout = 1;
      en_len = en_cycles;
      last_fall_cyc = cyc;
      low_cycles = 0;
    end
    if (!enable_reading && reading_done) begin
      low_cycles++;
      if (low_cycles > hold_cycles) begin
        reading_done  = 0;
        done_fall_cyc = cyc;
      end
    end
    check("fills_done", fills_done, exp_done);
    check("fills_skipped", fills_skipped, exp_skip);
    check("rd_timeout", rd_timeout, exp_timeout);
    prev_en    = enable_reading;
    prev_rd_en = hdr_fifo_rd_en;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && !fill_busy && !enable_reading && !reading_done &&
             !skip_pending) && n < budget) begin
      step();
      n++;
    end
    check("wait_idle_bound", n < budget, 1);
  endtask

  task automatic wait_en(input int budget);
    int n;
    n = 0;
    while (!enable_reading && n < budget) begin
      step();
      n++;
    end
    check("wait_en_bound", enable_reading, 1);
  endtask

  task automatic do_reset();
    fifo_q.delete();
    fifo_refresh();
    acq_enabled = 0;
    rand_mode   = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    step();
  endtask

  initial begin
    int n_fill, n_zero, pops_before;
    logic [22:0] ra;
    logic [23:0] rc;
    reset = 1;
    acq_enabled = 0;
    reading_done = 0;
    cur_desc = '0;
    fifo_refresh();

    // Single fill.
    do_reset();
    resp_delay = 40; hold_cycles = 0;
    push(23'h000100, 24'd16);
    wait_idle(500);
    check("single_fills_done", fills_done, 1);
    check("single_en_len", en_len >= 40, 1);

    // Zero-length descriptor followed by a real one.
    do_reset();
    resp_delay = 5;
    push(23'h000200, 24'd0);
    push(23'h000300, 24'd4);
    wait_idle(500);
    check("zero_skipped", fills_skipped, 1);
    check("zero_fills_done", fills_done, 1);

    // Back-to-back with reading_done held after the request drops.
    do_reset();
    resp_delay = 5; hold_cycles = 10;
    push(23'h000400, 24'd8);
    push(23'h000500, 24'd9);
    push(23'h000600, 24'd10);
    wait_idle(1000);
    check("b2b_fills_done", fills_done, 3);

    // acq_enabled blocks the pop.
    do_reset();
    hold_cycles = 0;
    acq_enabled = 1;
    push(23'h000700, 24'd2);
    pops_before = pop_count;
    repeat (100) step();
    check("acq_no_pop", pop_count - pops_before, 0);
    check("acq_busy_low", fill_busy, 0);
    acq_enabled = 0;
    step();
    check("acq_pop_latency", hdr_fifo_rd_en, 1);
    wait_idle(500);

    // Reset while the request is up.
    do_reset();
    resp_delay = 5;
    push(23'h000800, 24'd3);
    wait_idle(500);
    resp_delay = 1000;
    push(23'h000900, 24'd3);
    wait_en(50);
    repeat (3) step();
    reset = 1;
    step();
    check("mid_req_en", enable_reading, 0);
    check("mid_req_idle", fill_busy, 0);
    check("mid_req_fills", fills_done, 0);
    reset = 0;
    step();
    check("mid_req_no_repop", hdr_fifo_rd_en, 0);

`ifdef DDR3_RD_FILL_TIMEOUT_EN
    // Watchdog: reading_done never comes back.
    do_reset();
    resp_delay = 100000;
    push(23'h000A00, 24'd5);
    wait_idle(1000);
    check("to_en_len", en_len, TO_CYC - 1);
    check("to_flag", rd_timeout, 1);
    check("to_fills_done", fills_done, 0);
    repeat (20) step();
    check("to_sticky", rd_timeout, 1);
`endif

    // Randomised traffic.
    do_reset();
    rand_mode = 1;
    n_fill = 0;
    n_zero = 0;
    for (int i = 0; i < 30; i++) begin
      ra = 23'($urandom);
      rc = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 5000));
      if (rc == 24'd0) n_zero++;
      else n_fill++;
      push(ra, rc);
      if ($urandom_range(0, 4) == 0) begin
        acq_enabled = 1;
        repeat ($urandom_range(1, 20)) step();
        acq_enabled = 0;
      end
      repeat ($urandom_range(0, 60)) step();
    end
    wait_idle(20000);
    check("rand_fifo_drained", fifo_q.size(), 0);
    check("rand_fills_done", fills_done, n_fill);
    check("rand_fills_skipped", fills_skipped, n_zero);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
